// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one aligned load/store on a simple req/gnt/rvalid bus
// and produces a single writeback per instruction (ALU result, load data or misalign report).
module mem_access_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            in_valid_i,
  input  logic            mem_rd_en_i,
  input  logic            mem_wr_en_i,
  input  logic [XLEN-1:0] addr_mem_i,
  input  logic [XLEN-1:0] data_mem_wr_i,
  input  logic [2:0]      load_code_i,
  input  logic [2:0]      store_code_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [4:0]      addr_reg_wr_i,
  input  logic            reg_wr_en_i,

  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [XLEN/8-1:0] bus_wstrb_o,

  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i,

  output logic            hold_req_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_en_o,
  output logic            misalign_o
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e state_q, state_d;

  // Operation decode of the incoming instruction
  logic                is_store, is_load, is_mem, aligned, accept;
  logic [1:0]          size_log2;
  logic [NumBytes-1:0] strb_base;
  logic [OffW+2:0]     in_shamt;

  // Transaction context latched on acceptance
  logic                st_q;
  logic [2:0]          lcode_q;
  logic [OffW-1:0]     off_q;
  logic [XLEN-1:0]     baddr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [NumBytes-1:0] wstrb_q;
  logic [4:0]          rd_q;
  logic                rwe_q;

  // Writeback registers
  logic                wb_valid_q, wb_en_q, misalign_q;
  logic [4:0]          wb_addr_q;
  logic [XLEN-1:0]     wb_data_q;

  // Load extraction
  logic [OffW+2:0]     rd_shamt;
  logic [XLEN-1:0]     rshift;
  logic [XLEN-1:0]     load_ext;

  always_comb begin
    // A zero code with its enable set is not a memory op; a real store beats a load.
    is_store = mem_wr_en_i && (store_code_i != 3'd0) && (store_code_i <= 3'd4);
    is_load  = !is_store && mem_rd_en_i && (load_code_i != 3'd0);
    is_mem   = is_store || is_load;

    size_log2 = 2'd0;
    if (is_store) begin
      size_log2 = 2'(store_code_i - 3'd1);
    end else if (is_load) begin
      case (load_code_i)
        3'd2, 3'd6: size_log2 = 2'd1;
        3'd3, 3'd7: size_log2 = 2'd2;
        3'd4:       size_log2 = 2'd3;
        default:    size_log2 = 2'd0;
      endcase
    end

    strb_base = '0;
    case (size_log2)
      2'd0: begin
        aligned      = 1'b1;
        strb_base[0] = 1'b1;
      end
      2'd1: begin
        aligned        = ~addr_mem_i[0];
        strb_base[1:0] = '1;
      end
      2'd2: begin
        aligned        = (addr_mem_i[1:0] == 2'd0);
        strb_base[3:0] = '1;
      end
      default: begin
        aligned        = (addr_mem_i[2:0] == 3'd0);
        strb_base[7:0] = '1;
      end
    endcase

    in_shamt = {addr_mem_i[OffW-1:0], 3'b000};
  end

  always_comb begin
    rd_shamt = {off_q, 3'b000};
    rshift   = bus_rdata_i >> rd_shamt;
    case (lcode_q)
      3'd1:    load_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      3'd2:    load_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      3'd3:    load_ext = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
      3'd4:    load_ext = rshift;
      3'd5:    load_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
      3'd6:    load_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
      3'd7:    load_ext = {{(XLEN-32){1'b0}}, rshift[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Next state, hold request and bus drive; bus outputs are only live while requesting.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    hold_req_o  = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_wstrb_o = '0;
    case (state_q)
      StIdle: begin
        if (in_valid_i && is_mem && aligned) begin
          accept     = 1'b1;
          hold_req_o = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        hold_req_o  = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = st_q;
        bus_addr_o  = baddr_q;
        bus_wdata_o = wdata_q;
        bus_wstrb_o = wstrb_q;
        if (bus_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        hold_req_o = 1'b1;
        if (bus_rvalid_i) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      st_q       <= 1'b0;
      lcode_q    <= '0;
      off_q      <= '0;
      baddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_q       <= '0;
      rwe_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;

      if (state_q == StIdle && in_valid_i) begin
        if (!is_mem) begin
          wb_valid_q <= 1'b1;
          wb_data_q  <= alu_result_i;
          wb_addr_q  <= addr_reg_wr_i;
          wb_en_q    <= reg_wr_en_i;
        end else if (!aligned) begin
          wb_valid_q <= 1'b1;
          misalign_q <= 1'b1;
          wb_addr_q  <= addr_reg_wr_i;
        end
      end

      if (accept) begin
        st_q    <= is_store;
        lcode_q <= load_code_i;
        off_q   <= addr_mem_i[OffW-1:0];
        baddr_q <= {addr_mem_i[XLEN-1:OffW], {OffW{1'b0}}};
        wdata_q <= data_mem_wr_i << in_shamt;
        wstrb_q <= strb_base << addr_mem_i[OffW-1:0];
        rd_q    <= addr_reg_wr_i;
        rwe_q   <= reg_wr_en_i;
      end

      if (state_q == StWait && bus_rvalid_i) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= rd_q;
        if (!st_q) begin
          wb_data_q <= load_ext;
          wb_en_q   <= rwe_q;
        end
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o  = wb_addr_q;
  assign wb_data_o  = wb_data_q;
  assign wb_en_o    = wb_en_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random instructions checked against
// an arithmetic model of sizes, alignment, lane shifting and sign extension.
module tb_mem_access_stage;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid_i, mem_rd_en_i, mem_wr_en_i, reg_wr_en_i;
  logic [XLEN-1:0] addr_mem_i, data_mem_wr_i, alu_result_i;
  logic [2:0]      load_code_i, store_code_i;
  logic [4:0]      addr_reg_wr_i;
  logic            bus_req_o, bus_we_o;
  logic [XLEN-1:0] bus_addr_o, bus_wdata_o;
  logic [7:0]      bus_wstrb_o;
  logic            bus_gnt_i, bus_rvalid_i;
  logic [XLEN-1:0] bus_rdata_i;
  logic            hold_req_o, wb_valid_o, wb_en_o, misalign_o;
  logic [4:0]      wb_addr_o;
  logic [XLEN-1:0] wb_data_o;

  mem_access_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_wr_en_i   (mem_wr_en_i),
    .addr_mem_i    (addr_mem_i),
    .data_mem_wr_i (data_mem_wr_i),
    .load_code_i   (load_code_i),
    .store_code_i  (store_code_i),
    .alu_result_i  (alu_result_i),
    .addr_reg_wr_i (addr_reg_wr_i),
    .reg_wr_en_i   (reg_wr_en_i),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_wstrb_o   (bus_wstrb_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .hold_req_o    (hold_req_o),
    .wb_valid_o    (wb_valid_o),
    .wb_addr_o     (wb_addr_o),
    .wb_data_o     (wb_data_o),
    .wb_en_o       (wb_en_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ld_size(input logic [2:0] c);
    case (c)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic int unsigned st_size(input logic [2:0] c);
    if (c >= 3'd1 && c <= 3'd4) return 1 << (int'(c) - 1);
    return 0;
  endfunction

  function automatic logic [63:0] ld_value(input logic [2:0] c, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int unsigned n;
    logic [63:0] v, mask;
    n    = ld_size(c);
    v    = rdata >> (8 * (addr % 8));
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v    = v & mask;
    if (c <= 3'd4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic scramble(input logic iv);
    in_valid_i    = iv;
    mem_rd_en_i   = 1'($urandom_range(0, 1));
    mem_wr_en_i   = 1'($urandom_range(0, 1));
    addr_mem_i    = {$urandom, $urandom};
    data_mem_wr_i = {$urandom, $urandom};
    load_code_i   = 3'($urandom_range(0, 7));
    store_code_i  = 3'($urandom_range(0, 7));
    alu_result_i  = {$urandom, $urandom};
    addr_reg_wr_i = 5'($urandom_range(0, 31));
    reg_wr_en_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hold"}, 64'(hold_req_o), 64'd0);
    check({tag, "_req"}, 64'(bus_req_o), 64'd0);
    check({tag, "_we"}, 64'(bus_we_o), 64'd0);
    check({tag, "_addr"}, bus_addr_o, 64'd0);
    check({tag, "_wdata"}, bus_wdata_o, 64'd0);
    check({tag, "_wstrb"}, 64'(bus_wstrb_o), 64'd0);
    check({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
    check({tag, "_wba"}, 64'(wb_addr_o), 64'd0);
    check({tag, "_wbd"}, wb_data_o, 64'd0);
    check({tag, "_wbe"}, 64'(wb_en_o), 64'd0);
    check({tag, "_mis"}, 64'(misalign_o), 64'd0);
  endtask

  // Quiet cycle in IDLE: junk on inputs with in_valid low must do nothing.
  task automatic idle_cycle();
    scramble(1'b0);
    bus_gnt_i    = 1'($urandom_range(0, 1));
    bus_rvalid_i = 1'($urandom_range(0, 1));
    bus_rdata_i  = {$urandom, $urandom};
    @(negedge clk);
    check("idle_hold", 64'(hold_req_o), 64'd0);
    check("idle_req", 64'(bus_req_o), 64'd0);
    check("idle_wbv", 64'(wb_valid_o), 64'd0);
    @(posedge clk); #1;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
  endtask

  // Issue one instruction from IDLE and play the bus slave; called at posedge+1 in IDLE.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [63:0] addr,
                        input logic [63:0] data, input logic [2:0] lc, input logic [2:0] sc,
                        input logic [63:0] alu, input logic [4:0] rd, input logic we,
                        input int gd, input int rdly, input logic [63:0] rdata);
    logic        is_st, is_ld, mem, ok;
    int unsigned n;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    is_st = wr_en && (sc >= 3'd1) && (sc <= 3'd4);
    is_ld = !is_st && rd_en && (lc != 3'd0);
    mem   = is_st || is_ld;
    n     = is_st ? st_size(sc) : ld_size(lc);
    ok    = 1'b0;
    if (mem) ok = ((addr % 64'(n)) == 64'd0);
    exp_wdata = data << (8 * (addr % 8));
    exp_strb  = 8'(((1 << n) - 1) << (addr % 8));

    in_valid_i = 1'b1; mem_rd_en_i = rd_en; mem_wr_en_i = wr_en; addr_mem_i = addr;
    data_mem_wr_i = data; load_code_i = lc; store_code_i = sc; alu_result_i = alu;
    addr_reg_wr_i = rd; reg_wr_en_i = we;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'($urandom_range(0, 1)); bus_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    check("accept_hold", 64'(hold_req_o), 64'(mem && ok));
    check("accept_req", 64'(bus_req_o), 64'd0);
    check("prev_wb_clear", 64'(wb_valid_o), 64'd0);
    check("prev_mis_clear", 64'(misalign_o), 64'd0);
    @(posedge clk); #1;

    if (!(mem && ok)) begin
      scramble(1'b0);
      bus_rvalid_i = 1'b0;
      @(negedge clk);
      check("wb_valid", 64'(wb_valid_o), 64'd1);
      check("misalign", 64'(misalign_o), 64'(mem));
      check("wb_en", 64'(wb_en_o), mem ? 64'd0 : 64'(we));
      check("wb_hold", 64'(hold_req_o), 64'd0);
      check("wb_noreq", 64'(bus_req_o), 64'd0);
      if (!mem) begin
        check("alu_data", wb_data_o, alu);
        check("alu_addr", 64'(wb_addr_o), 64'(rd));
      end
      @(posedge clk); #1;
      return;
    end

    for (int k = 0; k <= gd; k++) begin
      scramble(1'($urandom_range(0, 1)));
      bus_gnt_i    = (k == gd);
      bus_rvalid_i = 1'($urandom_range(0, 1));
      bus_rdata_i  = {$urandom, $urandom};
      @(negedge clk);
      check("req", 64'(bus_req_o), 64'd1);
      check("req_we", 64'(bus_we_o), 64'(is_st));
      check("req_addr", bus_addr_o, addr & ~64'h7);
      if (is_st) begin
        check("req_wdata", bus_wdata_o, exp_wdata);
        check("req_wstrb", 64'(bus_wstrb_o), 64'(exp_strb));
      end
      check("req_hold", 64'(hold_req_o), 64'd1);
      check("req_nowb", 64'(wb_valid_o), 64'd0);
      @(posedge clk); #1;
    end
    bus_gnt_i = 1'b0;

    for (int k = 0; k <= rdly; k++) begin
      scramble(1'($urandom_range(0, 1)));
      bus_rvalid_i = (k == rdly);
      bus_rdata_i  = (k == rdly) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      check("wait_hold", 64'(hold_req_o), 64'd1);
      check("wait_noreq", 64'(bus_req_o), 64'd0);
      check("wait_nowb", 64'(wb_valid_o), 64'd0);
      @(posedge clk); #1;
    end

    scramble(1'($urandom_range(0, 1)));
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = {$urandom, $urandom};
    @(negedge clk);
    check("done_valid", 64'(wb_valid_o), 64'd1);
    check("done_en", 64'(wb_en_o), is_ld ? 64'(we) : 64'd0);
    check("done_mis", 64'(misalign_o), 64'd0);
    check("done_hold", 64'(hold_req_o), 64'd0);
    check("done_noreq", 64'(bus_req_o), 64'd0);
    if (is_ld) begin
      check("load_data", wb_data_o, ld_value(lc, addr, rdata));
      check("load_addr", 64'(wb_addr_o), 64'(rd));
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    scramble(1'b0);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // ALU writeback, SD, LB/LBU sign handling, SH with slow grant, misaligned LW
    run_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 3'd0, 64'h42, 5'd5, 1'b1, 0, 0, 64'h0);
    run_op(1'b0, 1'b1, 64'h1000, 64'h1122334455667788, 3'd0, 3'd4, 64'h0, 5'd1, 1'b1,
           0, 1, 64'h0);
    run_op(1'b1, 1'b0, 64'h1003, 64'h0, 3'd1, 3'd0, 64'h0, 5'd7, 1'b1, 1, 0,
           64'h00000000_80000000);
    run_op(1'b1, 1'b0, 64'h1003, 64'h0, 3'd5, 3'd0, 64'h0, 5'd8, 1'b1, 0, 2,
           64'h00000000_80000000);
    run_op(1'b0, 1'b1, 64'h2006, 64'hBEEF, 3'd0, 3'd2, 64'h0, 5'd2, 1'b0, 3, 0, 64'h0);
    run_op(1'b1, 1'b0, 64'h3002, 64'h0, 3'd3, 3'd0, 64'h0, 5'd9, 1'b1, 0, 0, 64'h0);
    repeat (2) idle_cycle();

    // Reset in the middle of a load's WAIT phase, then a stale response
    in_valid_i = 1'b1; mem_rd_en_i = 1'b1; mem_wr_en_i = 1'b0; addr_mem_i = 64'h4000;
    load_code_i = 3'd4; store_code_i = 3'd0; addr_reg_wr_i = 5'd3; reg_wr_en_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    check("rstwait_hold", 64'(hold_req_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    bus_rvalid_i = 1'b1; bus_rdata_i = {$urandom, $urandom};
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stale_nowb", 64'(wb_valid_o), 64'd0);
      check("stale_noreq", 64'(bus_req_o), 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)), {$urandom, $urandom},
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, giving the data, result and address width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have these execute-stage inputs:
- in_valid_i, 1: instruction present.
- mem_rd_en_i, 1: load.
- mem_wr_en_i, 1: store.
- addr_mem_i, XLEN: byte address.
- data_mem_wr_i, XLEN: store data, right-aligned.
- load_code_i, 3: 1=LB 2=LH 3=LW 4=LD 5=LBU 6=LHU 7=LWU, 0=none.
- store_code_i, 3: 1=SB 2=SH 3=SW 4=SD, 0=none.
- alu_result_i, XLEN.
- addr_reg_wr_i, 5.
- reg_wr_en_i, 1.
REQ-005 The module SHALL have these bus outputs:
- bus_req_o, 1.
- bus_we_o, 1.
- bus_addr_o, XLEN: 8-byte aligned.
- bus_wdata_o, XLEN: lane-shifted.
- bus_wstrb_o, XLEN/8.
REQ-006 The module SHALL have these bus inputs:
- bus_gnt_i, 1: request accepted.
- bus_rvalid_i, 1: response (read data or write completion).
- bus_rdata_i, XLEN.
REQ-007 The module SHALL have these outputs:
- hold_req_o, 1: pipeline hold request.
- wb_valid_o, 1.
- wb_addr_o, 5.
- wb_data_o, XLEN.
- wb_en_o, 1.
- misalign_o, 1.

Function
REQ-008 The FSM SHALL have states IDLE, REQ, WAIT, DONE, and SHALL enter IDLE on reset.
REQ-009 In IDLE with in_valid_i=1 and no memory op, the module SHALL next cycle drive wb_valid_o=1, wb_data_o=alu_result_i, and wb_addr_o/wb_en_o from the inputs (latency 1), then stay in IDLE.
REQ-010 In IDLE with in_valid_i=1, a memory op and an aligned address, the module SHALL latch all inputs, go to REQ and assert hold_req_o combinationally in that same cycle.
REQ-011 Alignment SHALL be: byte any address; half addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
REQ-012 For a misaligned op, the module SHALL do no bus access, pulse misalign_o for one cycle next cycle with wb_valid_o=1, wb_en_o=0, and stay in IDLE.
REQ-013 In REQ, bus_req_o SHALL be 1 and bus_we_o/addr/wdata/wstrb SHALL stay stable until bus_gnt_i=1, at which point the FSM goes to WAIT.
REQ-014 In WAIT, on bus_rvalid_i=1 the FSM SHALL go to DONE, capturing bus_rdata_i for loads.
REQ-015 The FSM SHALL ignore bus_rvalid_i before the grant, and SHALL NOT handle bus_rvalid_i in the grant cycle.
REQ-016 In DONE, wb_valid_o SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
- Loads: wb_data_o is the extracted lane, sign- or zero-extended per load_code, and wb_en_o is the latched reg_wr_en.
- Stores: wb_en_o=0.
REQ-017 hold_req_o SHALL be 1 from the accepting IDLE cycle through WAIT, and 0 in DONE and IDLE.
REQ-018 Store data SHALL be shifted left by 8*addr[2:0]; wstrb SHALL be (1/3/F/FF) shifted left by addr[2:0].
REQ-019 Load extraction SHALL first shift rdata right by 8*addr[2:0].
REQ-020 The module SHALL ignore in_valid_i outside IDLE.
REQ-021 If mem_rd_en_i and mem_wr_en_i are both 1, the store SHALL take priority.
REQ-022 Load and store codes of 0 with their enable set SHALL be treated as no memory op.

Reset
REQ-023 On rst=1 at a clock edge, all outputs SHALL be 0 and the FSM SHALL be IDLE, even mid-transaction, with no writeback.
REQ-024 After reset, the module SHALL ignore any bus_rvalid_i until it issues a new request.

Verification
REQ-025 SD addr 0x1000, data 0x1122334455667788, gnt same cycle, rvalid +2 -> strb=0xFF, wdata unchanged, one wb_valid with wb_en=0.
REQ-026 LB addr 0x1003, rdata 0x00000000_80000000 -> wb_data=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-027 SH addr 0x2006, data 0xBEEF, gnt delayed 3 cycles -> req/addr/wdata=0xBEEF<<48, strb=0xC0 stable 4 cycles; hold_req high throughout.
REQ-028 LW addr 0x3002 -> misalign_o pulse, bus_req never asserted, wb_en=0.
REQ-029 ALU op result 0x42, rd=5 -> wb_valid, wb_addr=5, wb_data=0x42 one cycle later, hold_req=0.
REQ-030 Assert rst during WAIT -> all outputs 0 next cycle; a late rvalid produces no wb_valid.
